regfile_wb_arbiter: RTL

//  Shares the single RegFile write port between two writeback sources: ALU/execute

---
 rtl/regfile_wb_arbiter_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_hold_slot.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and types for the RegFile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [ADDR_W-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0]     xdata_t;
  typedef logic [NUM_REGS-1:0] busy_t;

  typedef struct packed {
    reg_idx_t rd;
    xdata_t   data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requests, RegFile write port and decode hazard signals of the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic     alu_valid;
  logic     alu_ready;
  reg_idx_t alu_rd;
  xdata_t   alu_data;

  logic     ld_valid;
  logic     ld_ready;
  reg_idx_t ld_rd;
  xdata_t   ld_data;

  logic     rf_we;
  reg_idx_t rf_waddr;
  xdata_t   rf_wdata;

  logic     iss_valid;
  reg_idx_t iss_rd;
  reg_idx_t iss_rs1;
  reg_idx_t iss_rs2;
  logic     hazard;
  busy_t    busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  alu_ready, ld_ready, rf_we, rf_waddr, rf_wdata, hazard, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           iss_valid, iss_rd, iss_rs1, iss_rs2,
    output alu_ready, ld_ready, rf_we, rf_waddr, rf_wdata, hazard, busy_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// One-entry writeback hold slot; x0 requests are accepted and dropped.
// Latency 1 edge to hold; ready while empty or while being granted (back-to-back).
module wb_hold_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  output logic    in_ready,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    full,
  output wb_req_t held
);

  assign in_ready = !full || grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      held <= '0;
    end else if (in_valid && in_ready && (in_req.rd != '0)) begin
      full <= 1'b1;
      held <= in_req;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of ALU and load writebacks onto the registered RegFile port,
// plus the pending-write scoreboard; accept edge E -> rf_we high after E+1, losers stall.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t  alu_in, ld_in, alu_held, ld_held;
  logic     alu_full, ld_full;
  logic     alu_grant, ld_grant;
  src_e     last_grant;
  logic     rf_we_q;
  reg_idx_t rf_waddr_q;
  xdata_t   rf_wdata_q;
  busy_t    busy_q, set_mask, clr_mask;
  logic     hazard_c;

  assign alu_in = '{rd: bus.alu_rd, data: bus.alu_data};
  assign ld_in  = '{rd: bus.ld_rd,  data: bus.ld_data};

  wb_hold_slot u_alu_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.alu_valid),
    .in_ready (bus.alu_ready),
    .in_req   (alu_in),
    .grant    (alu_grant),
    .full     (alu_full),
    .held     (alu_held)
  );

  wb_hold_slot u_ld_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.ld_valid),
    .in_ready (bus.ld_ready),
    .in_req   (ld_in),
    .grant    (ld_grant),
    .full     (ld_full),
    .held     (ld_held)
  );

  // Under contention the source that did not win last time goes first.
  always_comb begin
    alu_grant = alu_full && (!ld_full  || (last_grant == SRC_LD));
    ld_grant  = ld_full  && (!alu_full || (last_grant == SRC_ALU));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      last_grant <= SRC_LD;
    end else begin
      rf_we_q <= alu_grant || ld_grant;
      if (alu_grant) begin
        rf_waddr_q <= alu_held.rd;
        rf_wdata_q <= alu_held.data;
        last_grant <= SRC_ALU;
      end else if (ld_grant) begin
        rf_waddr_q <= ld_held.rd;
        rf_wdata_q <= ld_held.data;
        last_grant <= SRC_LD;
      end
    end
  end

  always_comb begin
    hazard_c = bus.iss_valid &&
               (busy_q[bus.iss_rs1] || busy_q[bus.iss_rs2] || busy_q[bus.iss_rd]);
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid && !hazard_c && (bus.iss_rd != '0))
      set_mask = busy_t'(1) << bus.iss_rd;
    if (rf_we_q)
      clr_mask = busy_t'(1) << rf_waddr_q;
  end

  // Clear is applied before set so a same-edge issue keeps its register pending.
  always_ff @(posedge clk) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~busy_t'(1);
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.hazard    = hazard_c;
  assign bus.busy_mask = busy_q;

endmodule
